dot_prod_lanes: RTL and testbench

Parametrised multi-lane dot-product engine with two host-loadable vector memories. Each vector is split into `LANES` interleaved banks so `LANES` products are formed per cycle. Three reduction modes, arbitrary (unaligned) start index and length, and a host-access stall. Sits alongside the other generated compute kernels as a `main`-style accelerator.

---
 rtl/dot_prod_pkg.sv | 21 ++
 rtl/dot_prod_bank.sv | 32 +++
 rtl/dot_prod_lanes.sv | 174 +++++++++++++++++
 tb/tb_dot_prod_lanes.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dot_prod_pkg.sv
// Shared types and helpers for the multi-lane dot-product engine.
package dot_prod_pkg;

    typedef enum logic [1:0] {
        DOT  = 2'd0,
        SQA  = 2'd1,
        SUMA = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Rows touched by a run: the leading partial row counts as a full beat.
    function automatic int beat_count(input int start, input int len, input int lanes);
        return (start % lanes + len + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/dot_prod_bank.sv
// One interleaved element bank: synchronous write, asynchronous read.
module dot_prod_bank #(
    parameter int DATA_W = 27,
    parameter int ROWS   = 500,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDR_W-1:0] ROWS_A = ADDR_W'(ROWS);

    logic [DATA_W-1:0] mem [ROWS];
    logic              hit;

    // Rows past the end exist only in index arithmetic; they read as zero.
    assign hit = (addr < ROWS_A);

    // NOTE: storage is deliberately never reset; contents survive restarts.
    always_ff @(posedge clk) begin
        if (we && hit) begin
            mem[addr[IW-1:0]] <= wdata;
        end
    end

    assign rdata = hit ? mem[addr[IW-1:0]] : '0;

endmodule

// File: rtl/dot_prod_lanes.sv
// Multi-lane dot-product engine: host/engine bank mux, masked lane products,
// product register stage, adder tree, accumulator and run/drain/done control.
module dot_prod_lanes
    import dot_prod_pkg::*;
#(
    parameter int DATA_W = 27,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1000,
    parameter int LANES  = 2,
    parameter int ACC_W  = 64
) (
    input  logic                clk,
    input  logic                r_enable,
    input  logic [ADDR_W-1:0]   init_i,
    input  logic [ADDR_W:0]     init_len,
    input  logic [ACC_W-1:0]    init_acc,
    input  logic [1:0]          init_mode,
    input  logic                controlArr,
    input  logic                controlArrWEnable_a,
    input  logic                controlArrWEnable_b,
    input  logic [ADDR_W-1:0]   controlArrAddr_a,
    input  logic [ADDR_W-1:0]   controlArrAddr_b,
    input  logic [DATA_W-1:0]   controlArrWData_a,
    input  logic [DATA_W-1:0]   controlArrWData_b,
    output logic [DATA_W-1:0]   controlArrRData_a,
    output logic [DATA_W-1:0]   controlArrRData_b,
    output logic                w_enable,
    output logic [ACC_W-1:0]    result
);

    localparam int IDX_W  = ADDR_W + 2;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ROWS   = DEPTH / LANES;
    localparam int SHIFT  = $clog2(LANES);
    localparam logic [IDX_W-1:0] LANE_MASK = IDX_W'(LANES - 1);
    localparam logic [IDX_W-1:0] DEPTH_I   = IDX_W'(DEPTH);

    state_e                    state_q, state_d;
    mode_e                     mode_q;
    logic [IDX_W-1:0]          start_q, len_q, beats_q, beat_q;
    logic [ACC_W-1:0]          acc_q;
    logic                      p_valid_q;
    logic signed [PROD_W-1:0]  p_q [LANES];

    logic                      stall, issue;
    logic [IDX_W-1:0]          host_idx_a, host_idx_b, eng_row, end_idx;
    logic [IDX_W-1:0]          addr_a [LANES];
    logic [IDX_W-1:0]          addr_b [LANES];
    logic                      we_a [LANES];
    logic                      we_b [LANES];
    logic signed [DATA_W-1:0]  rd_a [LANES];
    logic signed [DATA_W-1:0]  rd_b [LANES];
    logic signed [PROD_W-1:0]  lane_prod [LANES];
    logic [DATA_W-1:0]         host_rd_a, host_rd_b;
    logic [ACC_W-1:0]          lane_sum;

    assign host_idx_a = IDX_W'(controlArrAddr_a);
    assign host_idx_b = IDX_W'(controlArrAddr_b);
    assign eng_row    = (start_q >> SHIFT) + beat_q;
    assign end_idx    = start_q + len_q;
    assign stall      = controlArr && (state_q == RUN || state_q == DRAIN);

    // Host owns every bank while controlArr is high; otherwise the engine row.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            addr_a[l] = controlArr ? (host_idx_a >> SHIFT) : eng_row;
            addr_b[l] = controlArr ? (host_idx_b >> SHIFT) : eng_row;
            we_a[l]   = controlArr && controlArrWEnable_a
                        && ((host_idx_a & LANE_MASK) == IDX_W'(l));
            we_b[l]   = controlArr && controlArrWEnable_b
                        && ((host_idx_b & LANE_MASK) == IDX_W'(l));
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dot_prod_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .ADDR_W(IDX_W)) u_bank_a (
            .clk   (clk),
            .we    (we_a[l]),
            .addr  (addr_a[l]),
            .wdata (controlArrWData_a),
            .rdata (rd_a[l])
        );
        dot_prod_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .ADDR_W(IDX_W)) u_bank_b (
            .clk   (clk),
            .we    (we_b[l]),
            .addr  (addr_b[l]),
            .wdata (controlArrWData_b),
            .rdata (rd_b[l])
        );
    end

    always_comb begin
        host_rd_a = '0;
        host_rd_b = '0;
        for (int l = 0; l < LANES; l++) begin
            if ((host_idx_a & LANE_MASK) == IDX_W'(l)) host_rd_a = rd_a[l];
            if ((host_idx_b & LANE_MASK) == IDX_W'(l)) host_rd_b = rd_b[l];
        end
    end

    assign controlArrRData_a = controlArr ? host_rd_a : 'x;
    assign controlArrRData_b = controlArr ? host_rd_b : 'x;

    // Lanes outside [start, start+len) or past DEPTH contribute nothing.
    always_comb begin
        logic [IDX_W-1:0] e;
        for (int l = 0; l < LANES; l++) begin
            e = (eng_row << SHIFT) + IDX_W'(l);
            lane_prod[l] = '0;
            if (e >= start_q && e < end_idx && e < DEPTH_I) begin
                case (mode_q)
                    SQA:     lane_prod[l] = PROD_W'(rd_a[l]) * PROD_W'(rd_a[l]);
                    SUMA:    lane_prod[l] = PROD_W'(rd_a[l]);
                    default: lane_prod[l] = PROD_W'(rd_a[l]) * PROD_W'(rd_b[l]);
                endcase
            end
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_sum = lane_sum + ACC_W'(p_q[l]);
        end
    end

    // NOTE: every local in always_comb is assigned before use, so no latch forms.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            RUN: begin
                if (beats_q == '0) begin
                    state_d = DONE;
                end else begin
                    issue = 1'b1;
                    if (beat_q == beats_q - 1'b1) state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment only.
    always_ff @(posedge clk) begin
        if (r_enable) begin
            state_q   <= RUN;
            acc_q     <= init_acc;
            p_valid_q <= 1'b0;
            beat_q    <= '0;
            start_q   <= IDX_W'(init_i);
            len_q     <= IDX_W'(init_len);
            mode_q    <= (init_mode == 2'd3) ? DOT : mode_e'(init_mode);
            beats_q   <= IDX_W'(beat_count(int'(init_i), int'(init_len), LANES));
        end else if (!stall) begin
            state_q   <= state_d;
            p_valid_q <= issue;
            if (issue)     beat_q <= beat_q + 1'b1;
            if (p_valid_q) acc_q  <= acc_q + lane_sum;
        end
    end

    // Product register needs no reset: p_valid_q qualifies its contents.
    always_ff @(posedge clk) begin
        if (!r_enable && !stall) begin
            p_q <= lane_prod;
        end
    end

    assign w_enable = (state_q == DONE);
    assign result   = acc_q;

endmodule

// File: tb/tb_dot_prod_lanes.sv
// Self-checking bench for dot_prod_lanes: spec vectors, stall/abort sequences,
// and randomized runs against a behavioural sum-of-products model.
module tb_dot_prod_lanes;

    localparam int DATA_W = 27;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1000;
    localparam int LANES  = 2;
    localparam int ACC_W  = 64;
    localparam int LIMIT  = 4000;

    logic                clk = 1'b0;
    logic                r_enable;
    logic [ADDR_W-1:0]   init_i;
    logic [ADDR_W:0]     init_len;
    logic [ACC_W-1:0]    init_acc;
    logic [1:0]          init_mode;
    logic                controlArr;
    logic                we_a, we_b;
    logic [ADDR_W-1:0]   addr_a, addr_b;
    logic [DATA_W-1:0]   wdata_a, wdata_b;
    logic [DATA_W-1:0]   rdata_a, rdata_b;
    logic                w_enable;
    logic [ACC_W-1:0]    result;

    int total = 0;
    int bad   = 0;
    int ma [DEPTH];
    int mb [DEPTH];

    typedef struct {
        int     fill;
        int     start;
        int     len;
        longint acc;
        int     mode;
        longint exp_res;
        int     exp_cyc;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    dot_prod_lanes dut (
        .clk                 (clk),
        .r_enable            (r_enable),
        .init_i              (init_i),
        .init_len            (init_len),
        .init_acc            (init_acc),
        .init_mode           (init_mode),
        .controlArr          (controlArr),
        .controlArrWEnable_a (we_a),
        .controlArrWEnable_b (we_b),
        .controlArrAddr_a    (addr_a),
        .controlArrAddr_b    (addr_b),
        .controlArrWData_a   (wdata_a),
        .controlArrWData_b   (wdata_b),
        .controlArrRData_a   (rdata_a),
        .controlArrRData_b   (rdata_b),
        .w_enable            (w_enable),
        .result              (result)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Fill patterns: 0 a=i b=1; 1 a=i b=2; 2 a=-3 b=1; 3 as 2 with a[0]=-2^26; 4 random.
    task automatic load(input int f);
        controlArr = 1'b1;
        we_a = 1'b1;
        we_b = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            case (f)
                0:       begin ma[i] = i;  mb[i] = 1; end
                1:       begin ma[i] = i;  mb[i] = 2; end
                2, 3:    begin ma[i] = -3; mb[i] = 1; end
                default: begin ma[i] = int'($urandom) >>> 5; mb[i] = int'($urandom) >>> 5; end
            endcase
            if (f == 3 && i == 0) ma[i] = -(1 << 26);
            addr_a  = ADDR_W'(i);
            addr_b  = ADDR_W'(i);
            wdata_a = DATA_W'(ma[i]);
            wdata_b = DATA_W'(mb[i]);
            tick();
        end
        we_a = 1'b0;
        we_b = 1'b0;
        controlArr = 1'b0;
    endtask

    task automatic start_run(input int s, input int l, input longint acc, input int m);
        r_enable  = 1'b1;
        init_i    = ADDR_W'(s);
        init_len  = (ADDR_W + 1)'(l);
        init_acc  = acc;
        init_mode = 2'(m);
        tick();
        r_enable  = 1'b0;
    endtask

    task automatic wait_done(input bit rnd_stall, output int cyc, output int stalls);
        cyc = 0;
        stalls = 0;
        while (!w_enable && cyc < LIMIT) begin
            if (rnd_stall) controlArr = ($urandom_range(0, 7) == 0);
            if (controlArr) stalls++;
            tick();
            cyc++;
        end
        controlArr = 1'b0;
    endtask

    function automatic longint model(input int s, input int l, input longint acc, input int m);
        longint sum = acc;
        for (int e = s; e < s + l && e < DEPTH; e++) begin
            case (m)
                1:       sum += longint'(ma[e]) * longint'(ma[e]);
                2:       sum += longint'(ma[e]);
                default: sum += longint'(ma[e]) * longint'(mb[e]);
            endcase
        end
        return sum;
    endfunction

    initial begin
        int cyc, stalls, cur_fill;

        vecs[0] = '{0, 0,   1000, 0, 0, 499500, 501};
        vecs[1] = '{0, 0,   0,    7, 0, 7,      1};
        vecs[2] = '{0, 999, 5,    0, 0, 999,    4};
        vecs[3] = '{1, 3,   4,    0, 0, 36,     4};
        vecs[4] = '{1, 3,   4,    0, 3, 36,     4};
        vecs[5] = '{2, 0,   10,   0, 1, 90,     6};
        vecs[6] = '{2, 0,   10,   5, 2, -25,    6};
        vecs[7] = '{3, 0,   1,    0, 1, 64'sd1 << 52, 2};
        vecs[8] = '{3, 1,   1,    0, 1, 9,      2};

        r_enable = 1'b1;
        init_i = '0; init_len = '0; init_acc = '0; init_mode = '0;
        controlArr = 1'b0; we_a = 1'b0; we_b = 1'b0;
        addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
        tick();
        tick();
        check("reset_w_enable", 64'(w_enable), 64'd0);
        r_enable = 1'b0;

        cur_fill = -1;
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].fill != cur_fill) begin
                load(vecs[i].fill);
                cur_fill = vecs[i].fill;
            end
            start_run(vecs[i].start, vecs[i].len, vecs[i].acc, vecs[i].mode);
            wait_done(1'b0, cyc, stalls);
            check($sformatf("vec%0d_cyc", i), 64'(cyc), 64'(vecs[i].exp_cyc));
            check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
        end

        // Host stall for cycles 100..104 with a read of a[17] mid-stall.
        load(0);
        start_run(0, 1000, 0, 0);
        cyc = 0;
        addr_a = ADDR_W'(17);
        while (!w_enable && cyc < LIMIT) begin
            controlArr = (cyc >= 100 && cyc <= 104);
            if (cyc == 102) begin
                #1;
                check("stall_host_read", 64'(rdata_a), 64'd17);
            end
            tick();
            cyc++;
        end
        controlArr = 1'b0;
        check("stall_cyc", 64'(cyc), 64'd506);
        check("stall_result", result, 64'd499500);

        // Abort mid-run at cycle 50, restarting with an end-straddling window.
        start_run(0, 1000, 0, 0);
        for (int c = 0; c < 50; c++) tick();
        start_run(998, 10, 0, 0);
        check("abort_w_enable", 64'(w_enable), 64'd0);
        wait_done(1'b0, cyc, stalls);
        check("abort_cyc", 64'(cyc), 64'd6);
        check("abort_result", result, 64'd1997);

        // Random data, windows, modes and host stalls against the model.
        load(4);
        for (int r = 0; r < 20; r++) begin
            int s, l, m, beats;
            longint acc, exp_res;
            s   = int'($urandom_range(0, 1023));
            l   = int'($urandom_range(0, 1100));
            m   = int'($urandom_range(0, 3));
            acc = {$urandom, $urandom};
            beats   = (s % LANES + l + LANES - 1) / LANES;
            exp_res = model(s, l, acc, m);
            start_run(s, l, acc, m);
            wait_done(1'b1, cyc, stalls);
            check($sformatf("rnd%0d_cyc", r), 64'(cyc), 64'(beats + 1 + stalls));
            check($sformatf("rnd%0d_result", r), result, exp_res);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
